bnn_issue_ctrl: RTL and testbench
=================================

Name: bnn_issue_ctrl

Overview:
- Sequencer in front of the BNN pipeline core. Accepts images from a loader on a valid/ready port and issues them into the core's non-stallable i_valid/i_data input.
- Tags each issued image with its ID and re-associates every o_valid/o_result with that ID, in order.
- Buffers results for a backpressured consumer.
- Gates weight/threshold reconfiguration: drains the pipeline before granting the loader permission to change i_weight_fc1/i_weight_fc2/i_threshold.

Parameters:
IMG_W, 784, image bit width (core i_data)
RES_W, 4, class result width (core o_result)
ID_W, 14, image ID width
MAX_INFLIGHT, 8, credit limit: images issued but not yet consumed at m side; also depth of tag FIFO and result FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_valid  in  1  image request valid
s_ready  out  1  image request accepted when s_valid&&s_ready
s_data  in  IMG_W  binarized image
s_id  in  ID_W  image ID
bnn_valid  out  1  to core i_valid
bnn_data  out  IMG_W  to core i_data
bnn_o_valid  in  1  core o_valid
bnn_o_result  in  RES_W  core o_result
m_valid  out  1  tagged result valid
m_ready  in  1  consumer ready
m_result  out  RES_W  class result
m_id  out  ID_W  ID of image that produced m_result
cfg_req  in  1  loader requests weight/threshold update
cfg_ack  out  1  core idle; weights may change while high
inflight  out  $clog2(MAX_INFLIGHT)+1  credit count
err_orphan  out  1  sticky: core result with tag FIFO empty
err_ovf  out  1  sticky: push into full result FIFO

Behaviour:
- Reset: while rst_n==0 at posedge, all of the following are cleared:
  - state<=RUN; both FIFOs flushed; credit=0.
  - bnn_valid=0, bnn_data=0, m_valid=0, m_result=0, m_id=0, cfg_ack=0, err_*=0.
  - Reset mid-operation discards in-flight tags. Any core output arriving after reset raises err_orphan; the system must reset the core too.
- Credit counter (inflight):
  - +1 on s handshake, -1 on m handshake, unchanged when both occur in the same cycle.
  - Never exceeds MAX_INFLIGHT.
- s_ready is combinational: (state==RUN) && !cfg_req && (inflight<MAX_INFLIGHT). It does not depend on s_valid.
- Issue (latency 1 cycle):
  - On s handshake at edge N: bnn_valid=1 and bnn_data=s_data during cycle N+1, and s_id is pushed to the tag FIFO at edge N.
  - Without a handshake, bnn_valid=0 and bnn_data holds its last value.
  - Back-to-back accepts give one image per cycle.
- Result capture:
  - On bnn_o_valid, pop the tag FIFO head and push {head_id, bnn_o_result} into the result FIFO.
  - Tag push and pop in the same cycle are both honoured.
  - With the tag FIFO empty: set err_orphan and drop the result.
  - With the result FIFO full (unreachable under credits): set err_ovf and drop the result.
- Output:
  - m_valid = result FIFO non-empty; m_result/m_id = head entry, show-ahead.
  - Entry pops on m_valid&&m_ready.
  - A result pushed at edge N is visible at m_* in cycle N+1.
  - Payload is stable while m_valid&&!m_ready.
- FSM:
  - RUN: issue allowed. cfg_req=1 -> DRAIN.
  - DRAIN: no issue. Go to CFG when the tag FIFO is empty and bnn_valid==0 (core has no outstanding image). Result FIFO contents may remain and continue to drain to m.
  - CFG: cfg_ack=1 (registered, asserted in the cycle after entry). cfg_req=0 -> RUN; cfg_ack drops the same edge.
  - cfg_req deasserted during DRAIN -> RUN directly; cfg_ack never asserted.
  - bnn_o_valid while in CFG -> err_orphan.
- Ordering: core is strictly in-order; IDs on m match issue order.

Test Plan:
- Reset, then 5 images IDs 0..4 on consecutive cycles; core model with fixed latency 3 returns results 7,2,1,0,4 -> bnn_valid high cycles 1..5 after accept; m emits (7,0),(2,1),(1,2),(0,3),(4,4) in order; inflight returns to 0.
- m_ready=0, stream 10 images -> s_ready drops after 8 accepts (inflight=8); no err_ovf. Raise m_ready -> 8 results drain, remaining 2 images accepted.
- cfg_req=1 with 3 images in core (latency 3) -> s_ready=0 immediately; cfg_ack rises only after the 3rd bnn_o_valid plus 1 cycle; cfg_req=0 -> cfg_ack=0 and s_ready=1 next cycle.
- Same-cycle s handshake and m handshake at inflight=8 -> inflight stays 8; accept permitted only if s_ready computed <8 (expect s_ready=0 at 8).
- Inject bnn_o_valid with no images issued -> err_orphan=1 sticky, m_valid stays 0; rst_n=0 one cycle clears it.
- Assert rst_n=0 with 4 images in flight -> all outputs zero next cycle; inflight=0; state RUN; subsequent image ID 9 yields m_id=9.

Source files
------------

// File: rtl/bnn_issue_ctrl.sv
// Issue sequencer for the BNN core: credit-limited image issue, ID tagging
// of in-order results, buffered result output and drain-before-reconfig.
module bnn_issue_ctrl #(
  parameter int IMG_W        = 784,
  parameter int RES_W        = 4,
  parameter int ID_W         = 14,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [IMG_W-1:0]                  s_data,
  input  logic [ID_W-1:0]                   s_id,
  output logic                              bnn_valid,
  output logic [IMG_W-1:0]                  bnn_data,
  input  logic                              bnn_o_valid,
  input  logic [RES_W-1:0]                  bnn_o_result,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [RES_W-1:0]                  m_result,
  output logic [ID_W-1:0]                   m_id,
  input  logic                              cfg_req,
  output logic                              cfg_ack,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              err_orphan,
  output logic                              err_ovf
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + RES_W;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [AW-1:0] PONE  = AW'(1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CFG   = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CW-1:0]   credit;

  logic [ID_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;
  logic [CW-1:0]   tag_cnt;

  logic [EW-1:0]   res_mem [MAX_INFLIGHT];
  logic [AW-1:0]   res_wr;
  logic [AW-1:0]   res_rd;
  logic [CW-1:0]   res_cnt;
  logic [EW-1:0]   res_head;

  logic s_hs;
  logic m_hs;
  logic tag_empty;
  logic tag_pop;
  logic res_empty;
  logic res_full;
  logic orphan;
  logic res_push;
  logic ovf;

  assign tag_empty = (tag_cnt == '0);
  assign res_empty = (res_cnt == '0);
  assign res_full  = (res_cnt == MAX_C);

  assign s_ready = (state == RUN) && !cfg_req && (credit < MAX_C);
  assign s_hs    = s_valid && s_ready;
  assign m_valid = !res_empty;
  assign m_hs    = m_valid && m_ready;

  // A result seen in CFG or with no tag outstanding has no owner.
  assign orphan   = bnn_o_valid && (tag_empty || (state == CFG));
  assign tag_pop  = bnn_o_valid && !tag_empty;
  assign res_push = bnn_o_valid && !orphan && !res_full;
  assign ovf      = bnn_o_valid && !orphan && res_full;

  assign res_head = res_mem[res_rd];
  assign m_result = res_empty ? '0 : res_head[RES_W-1:0];
  assign m_id     = res_empty ? '0 : res_head[EW-1:RES_W];
  assign inflight = credit;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!cfg_req)
          state_nxt = RUN;
        else if (tag_empty && !bnn_valid)
          state_nxt = CFG;
      end
      CFG:     if (!cfg_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_hs)
      tag_mem[tag_wr] <= s_id;
    if (res_push)
      res_mem[res_wr] <= {tag_mem[tag_rd], bnn_o_result};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      credit     <= '0;
      tag_wr     <= '0;
      tag_rd     <= '0;
      tag_cnt    <= '0;
      res_wr     <= '0;
      res_rd     <= '0;
      res_cnt    <= '0;
      bnn_valid  <= 1'b0;
      bnn_data   <= '0;
      cfg_ack    <= 1'b0;
      err_orphan <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ack   <= (state_nxt == CFG);
      bnn_valid <= s_hs;
      if (s_hs)
        bnn_data <= s_data;

      if (s_hs && !m_hs)
        credit <= credit + ONE;
      else if (!s_hs && m_hs)
        credit <= credit - ONE;

      if (s_hs)
        tag_wr <= tag_wr + PONE;
      if (tag_pop)
        tag_rd <= tag_rd + PONE;
      if (s_hs && !tag_pop)
        tag_cnt <= tag_cnt + ONE;
      else if (!s_hs && tag_pop)
        tag_cnt <= tag_cnt - ONE;

      if (res_push)
        res_wr <= res_wr + PONE;
      if (m_hs)
        res_rd <= res_rd + PONE;
      if (res_push && !m_hs)
        res_cnt <= res_cnt + ONE;
      else if (!res_push && m_hs)
        res_cnt <= res_cnt - ONE;

      if (orphan)
        err_orphan <= 1'b1;
      if (ovf)
        err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bnn_issue_ctrl.sv
// Scoreboard bench for bnn_issue_ctrl with a fixed-latency core model
// and randomized traffic and consumer backpressure.
module tb_bnn_issue_ctrl;

  localparam int IMG_W = 784;
  localparam int RES_W = 4;
  localparam int ID_W  = 14;
  localparam int MAXI  = 8;
  localparam int CW    = $clog2(MAXI) + 1;
  localparam int EW    = ID_W + RES_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IMG_W-1:0] s_data = '0;
  logic [ID_W-1:0]  s_id = '0;
  logic             bnn_valid;
  logic [IMG_W-1:0] bnn_data;
  logic             bnn_o_valid;
  logic [RES_W-1:0] bnn_o_result;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [RES_W-1:0] m_result;
  logic [ID_W-1:0]  m_id;
  logic             cfg_req = 1'b0;
  logic             cfg_ack;
  logic [CW-1:0]    inflight;
  logic             err_orphan;
  logic             err_ovf;

  bnn_issue_ctrl #(
    .IMG_W(IMG_W), .RES_W(RES_W), .ID_W(ID_W), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_id(s_id),
    .bnn_valid(bnn_valid), .bnn_data(bnn_data),
    .bnn_o_valid(bnn_o_valid), .bnn_o_result(bnn_o_result),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_id(m_id),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .inflight(inflight),
    .err_orphan(err_orphan), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Core model: latency 3, result is the low nibble of the image.
  logic [2:0]       pv;
  logic [RES_W-1:0] pr [3];
  logic             inj = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], bnn_valid};
      pr[0] <= bnn_data[RES_W-1:0];
      pr[1] <= pr[0];
      pr[2] <= pr[1];
    end
  end

  assign bnn_o_valid  = pv[2] | inj;
  assign bnn_o_result = pr[2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input bit ok, input string msg);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", nm, msg);
    end
  endtask

  logic [EW-1:0] expq[$];

  // Monitor: pops expected {id,result} on every m handshake.
  logic             exp_bv;
  logic [IMG_W-1:0] exp_bd;
  logic [CW-1:0]    mcnt;
  logic             orph_m;
  logic             pm_v;
  logic             pm_r;
  logic [ID_W-1:0]  pm_id;
  logic [RES_W-1:0] pm_res;
  logic [EW-1:0]    e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_bv = 1'b0;
      exp_bd = '0;
      mcnt   = '0;
      orph_m = 1'b0;
      pm_v   = 1'b0;
      pm_r   = 1'b0;
      expq.delete();
    end else begin
      chk("bnn_valid", bnn_valid == exp_bv,
          $sformatf("got %0b want %0b", bnn_valid, exp_bv));
      chk("bnn_data", bnn_data == exp_bd,
          $sformatf("got %0h want %0h", bnn_data, exp_bd));
      chk("inflight", inflight == mcnt,
          $sformatf("got %0d want %0d", inflight, mcnt));
      chk("err_ovf", err_ovf == 1'b0, $sformatf("got %0b want 0", err_ovf));
      chk("err_orphan", err_orphan == orph_m,
          $sformatf("got %0b want %0b", err_orphan, orph_m));
      if (pm_v && !pm_r)
        chk("m_hold", m_valid && m_id == pm_id && m_result == pm_res,
            $sformatf("got v=%0b id=%0d r=%0d want v=1 id=%0d r=%0d",
                      m_valid, m_id, m_result, pm_id, pm_res));
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("m_unexpected", 1'b0,
              $sformatf("got id=%0d r=%0d want none", m_id, m_result));
        end else begin
          e = expq.pop_front();
          chk("m_result", m_id == e[EW-1:RES_W] && m_result == e[RES_W-1:0],
              $sformatf("got id=%0d r=%0d want id=%0d r=%0d",
                        m_id, m_result, e[EW-1:RES_W], e[RES_W-1:0]));
        end
      end
      exp_bv = s_valid && s_ready;
      if (exp_bv)
        exp_bd = s_data;
      if (s_valid && s_ready)
        mcnt = mcnt + CW'(1);
      if (m_valid && m_ready)
        mcnt = mcnt - CW'(1);
      if (inj)
        orph_m = 1'b1;
      pm_v   = m_valid;
      pm_r   = m_ready;
      pm_id  = m_id;
      pm_res = m_result;
    end
  end

  function automatic logic [IMG_W-1:0] rimg();
    logic [IMG_W-1:0] r;
    for (int i = 0; i < IMG_W; i++)
      r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [ID_W-1:0] id, input logic [IMG_W-1:0] d);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_id    = id;
    s_data  = d;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = s_ready;
      if (acc)
        expq.push_back({id, d[RES_W-1:0]});
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!acc)
      chk("send_timeout", 1'b0, $sformatf("got no accept want accept id=%0d", id));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((expq.size() != 0 || inflight != '0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle", expq.size() == 0 && inflight == '0,
        $sformatf("got q=%0d inflight=%0d want 0/0", expq.size(), inflight));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out", !bnn_valid && bnn_data == '0 && !m_valid &&
        m_result == '0 && m_id == '0 && !cfg_ack && inflight == '0,
        $sformatf("got bv=%0b mv=%0b mr=%0d mid=%0d ack=%0b inf=%0d want zeros",
                  bnn_valid, m_valid, m_result, m_id, cfg_ack, inflight));
    chk("rst_err", !err_orphan && !err_ovf,
        $sformatf("got orph=%0b ovf=%0b want 0/0", err_orphan, err_ovf));
    chk("rst_s_ready", s_ready == 1'b1, $sformatf("got %0b want 1", s_ready));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int res5 [5] = '{7, 2, 1, 0, 4};
    logic [IMG_W-1:0] d;
    int cyc;
    int k;
    int first;
    int ov;
    bit any_ack;
    bit done;

    @(posedge clk);
    #1;
    do_reset();

    // Five back-to-back images with fixed results
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = rimg();
      d[RES_W-1:0] = RES_W'(res5[i]);
      send(ID_W'(i), d);
    end
    wait_idle();

    // Credit limit with a stalled consumer
    m_ready = 1'b0;
    fork
      for (int i = 0; i < 10; i++)
        send(ID_W'(100 + i), rimg());
      begin
        repeat (20) @(negedge clk);
        chk("credit_full", inflight == CW'(MAXI) && !s_ready && expq.size() == 8,
            $sformatf("got inf=%0d rdy=%0b q=%0d want 8/0/8",
                      inflight, s_ready, expq.size()));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_idle();

    // Drain then grant configuration
    send(ID_W'(200), rimg());
    send(ID_W'(201), rimg());
    send(ID_W'(202), rimg());
    cfg_req = 1'b1;
    @(negedge clk);
    chk("cfg_block", s_ready == 1'b0, $sformatf("got %0b want 0", s_ready));
    k = -1;
    first = -1;
    ov = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0)
        @(negedge clk);
      if (bnn_o_valid) begin
        ov++;
        k = cyc;
      end
      if (cfg_ack && first < 0)
        first = cyc;
    end
    chk("cfg_ack_time", ov == 3 && first == k + 2,
        $sformatf("got ov=%0d ack@%0d want ov=3 ack@%0d", ov, first, k + 2));
    @(posedge clk);
    #1;
    cfg_req = 1'b0;
    @(negedge clk);
    chk("cfg_hold", cfg_ack && !s_ready,
        $sformatf("got ack=%0b rdy=%0b want 1/0", cfg_ack, s_ready));
    @(negedge clk);
    chk("cfg_release", !cfg_ack && s_ready,
        $sformatf("got ack=%0b rdy=%0b want 0/1", cfg_ack, s_ready));
    @(posedge clk);
    #1;
    wait_idle();

    // Request withdrawn during drain never acknowledges
    send(ID_W'(210), rimg());
    send(ID_W'(211), rimg());
    cfg_req = 1'b1;
    any_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      any_ack |= cfg_ack;
      @(posedge clk);
      #1;
    end
    cfg_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_ack |= cfg_ack;
    end
    chk("drain_abort", !any_ack, $sformatf("got ack=%0b want 0", any_ack));
    @(posedge clk);
    #1;
    wait_idle();

    // Full credits with simultaneous consume
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(ID_W'(300 + i), rimg());
    @(negedge clk);
    chk("full_ready", inflight == CW'(MAXI) && !s_ready,
        $sformatf("got inf=%0d rdy=%0b want 8/0", inflight, s_ready));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send(ID_W'(308), rimg());
    send(ID_W'(309), rimg());
    wait_idle();

    // Orphan result
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    @(negedge clk);
    chk("orphan_set", err_orphan && !m_valid,
        $sformatf("got orph=%0b mv=%0b want 1/0", err_orphan, m_valid));
    repeat (3) @(negedge clk);
    chk("orphan_sticky", err_orphan == 1'b1, $sformatf("got %0b want 1", err_orphan));
    @(posedge clk);
    #1;
    do_reset();

    // Reset with images in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(ID_W'(400 + i), rimg());
    do_reset();
    m_ready = 1'b1;
    send(ID_W'(9), rimg());
    wait_idle();

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(ID_W'($urandom), rimg());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
